// File: rtl/spi_controller_if.sv
// Host-side request/response bundle for spi_controller.
// master = requester (drives request fields), slave = controller.
interface spi_controller_if;
  logic        i_Valid;
  logic        o_Ready;
  logic        i_WriteEnable;
  logic [14:0] i_RegisterNumber;
  logic [15:0] i_RegisterValue;
  logic        o_Done;
  logic [15:0] o_ReadData;

  modport master (
    output i_Valid,
    output i_WriteEnable,
    output i_RegisterNumber,
    output i_RegisterValue,
    input  o_Ready,
    input  o_Done,
    input  o_ReadData
  );

  modport slave (
    input  i_Valid,
    input  i_WriteEnable,
    input  i_RegisterNumber,
    input  i_RegisterValue,
    output o_Ready,
    output o_Done,
    output o_ReadData
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 master: one 32-bit frame per accepted request.
// Ports: i_Clock, i_Reset (sync, active-high), bus (request/response),
//        o_SPI_SCK, o_SPI_MOSI, i_SPI_MISO (serial pins).
module spi_controller #(
  parameter int CLKS_PER_HALF_BIT = 4,
  parameter int GAP_CYCLES        = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  spi_controller_if.slave  bus,
  output logic             o_SPI_SCK,
  output logic             o_SPI_MOSI,
  input  logic             i_SPI_MISO
);

  localparam int HW = (CLKS_PER_HALF_BIT > GAP_CYCLES) ?
                      CLKS_PER_HALF_BIT : GAP_CYCLES;
  localparam int CW = $clog2(HW);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]    state;
  logic [31:0]   tx;
  logic [15:0]   rx;
  logic [4:0]    bit_cnt;
  logic [CW-1:0] half_cnt;
  logic          sck;
  logic          ready;
  logic          done;
  logic [15:0]   read_data;

  // MOSI is the top of the transmit register; it is cleared
  // whenever the line must idle low.
  assign o_SPI_MOSI     = tx[31];
  assign o_SPI_SCK      = sck;
  assign bus.o_Ready    = ready;
  assign bus.o_Done     = done;
  assign bus.o_ReadData = read_data;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= IDLE;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      half_cnt  <= '0;
      sck       <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      read_data <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_Valid) begin
            tx       <= {bus.i_WriteEnable,
                         bus.i_RegisterNumber,
                         bus.i_RegisterValue};
            ready    <= 1'b0;
            bit_cnt  <= 5'd31;
            half_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_cnt != HALF_LAST) begin
            half_cnt <= half_cnt + CW'(1);
          end else begin
            half_cnt <= '0;
            if (!sck) begin
              sck <= 1'b1;
              // 16-bit window keeps only the last 16 bits received
              rx  <= {rx[14:0], i_SPI_MISO};
            end else begin
              sck <= 1'b0;
              if (bit_cnt == 5'd0) begin
                tx    <= '0;
                state <= GAP;
              end else begin
                bit_cnt <= bit_cnt - 5'd1;
                tx      <= {tx[30:0], 1'b0};
              end
            end
          end
        end
        GAP: begin
          if (half_cnt != GAP_LAST) begin
            half_cnt <= half_cnt + CW'(1);
          end else begin
            half_cnt  <= '0;
            done      <= 1'b1;
            read_data <= rx;
            ready     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller.
// Frame-level model plus directed requests on two instances.
module tb_spi_controller;
  localparam int C  = 2;
  localparam int G  = 4;
  localparam int L  = 64 * C + G;
  localparam int CB = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_controller_if bus_a ();
  spi_controller_if bus_b ();
  logic sck_a, mosi_a, miso_a;
  logic sck_b, mosi_b;

  spi_controller #(.CLKS_PER_HALF_BIT(C), .GAP_CYCLES(G)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .bus(bus_a),
    .o_SPI_SCK(sck_a), .o_SPI_MOSI(mosi_a), .i_SPI_MISO(miso_a));

  spi_controller #(.CLKS_PER_HALF_BIT(CB), .GAP_CYCLES(4)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .bus(bus_b),
    .o_SPI_SCK(sck_b), .o_SPI_MOSI(mosi_b), .i_SPI_MISO(1'b0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- frame model for dut_a ----------------
  int          cyc = 0;
  bit          active = 0;
  int          done_at = 0;
  logic [31:0] frame_q = '0;
  logic [31:0] miso_next = '0;
  logic [31:0] miso_cur = '0;
  logic [31:0] mosi_bits = '0;
  logic [15:0] rd_exp = '0;
  logic [5:0]  rise_cnt = '0;
  int          total_rises = 0;
  logic        sck_prev = 1'b0;
  logic [31:0] last_bits = '0;
  int          last_rises = 0;
  bit          run = 0;

  // slave returns its word MSB first, next bit after each rise
  assign miso_a = rise_cnt[5] ? 1'b0 : miso_cur[~rise_cnt[4:0]];

  always @(posedge clk) begin : model
    bit ready_pre;
    ready_pre = !(active && cyc < done_at);
    cyc++;
    if (sck_a && !sck_prev) begin
      total_rises++;
      if (!rise_cnt[5]) mosi_bits[~rise_cnt[4:0]] = mosi_a;
      if (rise_cnt != 6'h3f) rise_cnt = rise_cnt + 6'd1;
    end
    sck_prev = sck_a;
    if (rst) begin
      active = 0;
      rd_exp = '0;
    end else begin
      if (active && cyc == done_at) begin
        rd_exp     = miso_cur[15:0];
        last_bits  = mosi_bits;
        last_rises = int'(rise_cnt);
      end
      if (ready_pre && bus_a.i_Valid) begin
        active    = 1;
        done_at   = cyc + L;
        frame_q   = {bus_a.i_WriteEnable, bus_a.i_RegisterNumber,
                     bus_a.i_RegisterValue};
        miso_cur  = miso_next;
        mosi_bits = '0;
        rise_cnt  = '0;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit busy;
    if (run) begin
      busy = active && cyc < done_at;
      chk("ready", bus_a.o_Ready, !busy);
      chk("done", bus_a.o_Done, active && cyc == done_at);
      chk("read_data", bus_a.o_ReadData, rd_exp);
      if (!busy) begin
        chk("sck_idle", sck_a, 1'b0);
        chk("mosi_idle", mosi_a, 1'b0);
      end
      if (active && cyc == done_at) begin
        chk("mosi_frame", last_bits, frame_q);
        chk("rises_frame", last_rises, 32);
      end
    end
  end

  // ---------------- phase/setup monitor for dut_b ----------------
  logic sb_prev = 1'b0;
  logic mb_prev = 1'b0;
  int   hi = 0, lo = 0, stab = 0, rises_b = 0;
  bit   b_first = 1;

  always @(negedge clk) begin : mon_b
    if (run) begin
      if (sck_b && !sb_prev) begin
        rises_b++;
        if (!b_first) chk("b_lo_phase", lo, CB);
        b_first = 0;
        chk("b_mosi_setup", stab >= CB, 1'b1);
        hi = 1;
      end else if (!sck_b && sb_prev) begin
        chk("b_hi_phase", hi, CB);
        lo = 1;
      end else if (sck_b) begin
        hi++;
      end else begin
        lo++;
      end
      if (mosi_b != mb_prev) stab = 1;
      else stab++;
      sb_prev = sck_b;
      mb_prev = mosi_b;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_a(input logic we, input logic [14:0] rn,
                       input logic [15:0] rv);
    bus_a.i_WriteEnable    = we;
    bus_a.i_RegisterNumber = rn;
    bus_a.i_RegisterValue  = rv;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n++;
      if (bus_a.o_Done) break;
    end
    chk("done_seen", bus_a.o_Done, 1'b1);
  endtask

  task automatic req_a(input logic we, input logic [14:0] rn,
                       input logic [15:0] rv, input logic [31:0] w,
                       output int lat);
    set_a(we, rn, rv);
    miso_next = w;
    bus_a.i_Valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus_a.i_Valid = 1'b0;
      if (bus_a.o_Done) break;
    end
    chk("done_seen", bus_a.o_Done, 1'b1);
  endtask

  initial begin
    int lat;
    int r0;
    rst = 1'b1;
    bus_a.i_Valid = 1'b0;
    set_a(1'b0, '0, '0);
    bus_b.i_Valid = 1'b1;
    bus_b.i_WriteEnable = 1'b0;
    bus_b.i_RegisterNumber = '0;
    bus_b.i_RegisterValue = '0;
    repeat (3) @(negedge clk);
    bus_b.i_Valid = 1'b0;
    run = 1;
    chk("rst_ready", bus_a.o_Ready, 1'b1);
    chk("rst_b_ready", bus_b.o_Ready, 1'b1);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    chk("idle_rises", total_rises, 0);

    req_a(1'b1, 15'h4005, 16'h1234, 32'hDEAD_8001, lat);
    chk("lat_132", lat, 133);
    chk("frame_lit", last_bits, 32'hC005_1234);
    chk("rd_lit", bus_a.o_ReadData, 16'h8001);
    repeat (10) @(negedge clk);
    chk("rd_held", bus_a.o_ReadData, 16'h8001);

    req_a(1'b0, 15'h7FFF, 16'hFFFF, 32'h0000_5A5A, lat);
    chk("we0_bit31", last_bits[31], 1'b0);
    chk("frame_we0", last_bits, 32'h7FFF_FFFF);
    chk("rd_5a5a", bus_a.o_ReadData, 16'h5A5A);
    repeat (3) @(negedge clk);

    r0 = total_rises;
    set_a(1'b1, 15'h0001, 16'hAAAA);
    miso_next = 32'h1234_0F0F;
    bus_a.i_Valid = 1'b1;
    repeat (5) @(negedge clk);
    set_a(1'b1, 15'h1111, 16'h2222);
    miso_next = 32'hFFFF_C3C3;
    wait_done_a(lat);
    chk("rd_0f0f", bus_a.o_ReadData, 16'h0F0F);
    @(negedge clk);
    chk("accept_in_done", bus_a.o_Ready, 1'b0);
    chk("b2b_bit31", mosi_a, 1'b1);
    bus_a.i_Valid = 1'b0;
    repeat (7) @(negedge clk);
    set_a(1'b0, 15'h7777, 16'h3333);
    wait_done_a(lat);
    chk("b2b_frame", last_bits, 32'h9111_2222);
    chk("b2b_rises", total_rises - r0, 64);
    chk("rd_c3c3", bus_a.o_ReadData, 16'hC3C3);
    repeat (2) @(negedge clk);

    set_a(1'b1, 15'h5555, 16'hAAAA);
    miso_next = 32'hFFFF_FFFF;
    bus_a.i_Valid = 1'b1;
    @(negedge clk);
    bus_a.i_Valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sck_a && rise_cnt == 6'd9) break;
      @(negedge clk);
    end
    chk("rise10_seen", sck_a && rise_cnt == 6'd9, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sck", sck_a, 1'b0);
    chk("abort_mosi", mosi_a, 1'b0);
    chk("abort_rd", bus_a.o_ReadData, 16'h0000);
    chk("abort_done", bus_a.o_Done, 1'b0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("abort_rd_held", bus_a.o_ReadData, 16'h0000);
    req_a(1'b1, 15'h0ABC, 16'h0DEF, 32'h0000_7E57, lat);
    chk("post_abort_lat", lat, 133);
    chk("post_abort_rd", bus_a.o_ReadData, 16'h7E57);

    b_first = 1;
    r0 = rises_b;
    bus_b.i_WriteEnable = 1'b1;
    bus_b.i_RegisterNumber = 15'h2AAA;
    bus_b.i_RegisterValue = 16'h5555;
    bus_b.i_Valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus_b.i_Valid = 1'b0;
      if (bus_b.o_Done) break;
    end
    chk("b_done_seen", bus_b.o_Done, 1'b1);
    chk("b_latency", lat, 325);
    chk("b_rises", rises_b - r0, 32);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
